// File: rtl/alu_pkg.sv
// Shared definitions for the ALU, its request arbiter and the benches that drive them.
package alu_pkg;

    localparam int unsigned ALU_N = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;

endpackage

// File: rtl/alu.sv
// Registered N-bit ALU: result and flags update only on cycles with en high.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned N = ALU_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    input  logic         en,
    output logic [N-1:0] result_out,
    output logic         flag_carry,
    output logic         flag_zero
);

    // Top bit carries the adder carry-out, subtract borrow or shifted-out bit.
    logic [N:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_SHL:  wide = {a, 1'b0};
            default: wide = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_out <= '0;
            flag_carry <= 1'b0;
            flag_zero  <= 1'b0;
        end else if (en) begin
            result_out <= wide[N-1:0];
            flag_carry <= wide[N];
            flag_zero  <= (wide[N-1:0] == '0);
        end
    end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    int unsigned j;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[IDW'(j)]) begin
                grant[IDW'(j)] = 1'b1;
                idx            = IDW'(j);
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NREQ requesters; one transaction at a time, round-robin order.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N    = ALU_N,
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [2:0]      alu_op,
    output logic            alu_en,
    input  logic [N-1:0]    alu_result,
    input  logic            alu_carry,
    input  logic            alu_zero,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [N-1:0]    rsp_result,
    output logic            rsp_carry,
    output logic            rsp_zero
);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;
    logic [2:0]      sel_op;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win)
    );

    // Gated by rst so the grant is low throughout reset, not just after the first edge.
    assign req_ready = (state == S_IDLE && !rst) ? grant : '0;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[i*N +: N];
                sel_b  = req_b[i*N +: N];
                sel_op = req_op[i*3 +: 3];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_en     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        alu_op <= sel_op;
                        alu_en <= 1'b1;
                        rsp_id <= win;
                        ptr    <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_en <= 1'b0;
                    state  <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    rsp_result <= alu_result;
                    rsp_carry  <= alu_carry;
                    rsp_zero   <= alu_zero;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter driving a real alu: scoreboard against a behavioural model, plus an NREQ=3 wrap check.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned N     = 8;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned IDW   = 1;
    localparam int unsigned NREQ3 = 3;
    localparam int unsigned IDW3  = 2;

    typedef struct {
        int         id;
        logic [N-1:0] res;
        logic       c;
        logic       z;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*N-1:0] req_a, req_b;
    logic [NREQ*3-1:0] req_op;
    logic [N-1:0]      alu_a, alu_b, alu_result;
    logic [2:0]        alu_op;
    logic              alu_en, alu_carry, alu_zero;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_result;
    logic              rsp_carry, rsp_zero;

    logic [NREQ3-1:0]   req_valid3, req_ready3;
    logic [NREQ3*N-1:0] req_a3, req_b3;
    logic [NREQ3*3-1:0] req_op3;
    logic [N-1:0]       alu_a3, alu_b3, alu_result3;
    logic [2:0]         alu_op3;
    logic               alu_en3, alu_carry3, alu_zero3;
    logic               rsp_valid3, rsp_ready3;
    logic [IDW3-1:0]    rsp_id3;
    logic [N-1:0]       rsp_result3;
    logic               rsp_carry3, rsp_zero3;

    alu_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
    );

    alu #(.N(N)) u_alu (
        .clk(clk), .rst(rst), .a(alu_a), .b(alu_b), .op(alu_op), .en(alu_en),
        .result_out(alu_result), .flag_carry(alu_carry), .flag_zero(alu_zero)
    );

    alu_arbiter #(.N(N), .NREQ(NREQ3), .IDW(IDW3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_en(alu_en3),
        .alu_result(alu_result3), .alu_carry(alu_carry3), .alu_zero(alu_zero3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_result(rsp_result3), .rsp_carry(rsp_carry3), .rsp_zero(rsp_zero3)
    );

    alu #(.N(N)) u_alu3 (
        .clk(clk), .rst(rst), .a(alu_a3), .b(alu_b3), .op(alu_op3), .en(alu_en3),
        .result_out(alu_result3), .flag_carry(alu_carry3), .flag_zero(alu_zero3)
    );

    int tests = 0;
    int fails = 0;
    int en_count = 0;

    rsp_t exp_q[$];
    rsp_t rsp_log[$];

    // Reference model: transaction phase counter and round-robin pointer.
    int mphase = 0;
    int mptr = 0;
    logic [N-1:0] opa[NREQ];
    logic [N-1:0] opb[NREQ];
    logic [2:0]   opo[NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t model_op(input int id, input int op, input int a, input int b);
        rsp_t r;
        int   v;
        int   m;
        m    = 1 << N;
        r.id = id;
        r.c  = 1'b0;
        case (op)
            0: begin v = a + b; r.c = (v >= m); v = v % m; end
            1: begin r.c = (a < b); v = (a - b + m) % m; end
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            5: begin r.c = (a >= m / 2); v = (a * 2) % m; end
            default: v = 0;
        endcase
        r.res = v[N-1:0];
        r.z   = (v == 0);
        return r;
    endfunction

    task automatic step(input logic [NREQ-1:0] v, input logic rdy);
        logic [NREQ-1:0] eg;
        int widx;
        int j;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rdy;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N]  = opa[i];
            req_b[i*N +: N]  = opb[i];
            req_op[i*3 +: 3] = opo[i];
        end
        eg   = '0;
        widx = -1;
        if (mphase == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (mptr + k) % NREQ;
                if (widx < 0 && v[j]) begin
                    widx  = j;
                    eg[j] = 1'b1;
                end
            end
        end
        #1;
        check("req_ready", req_ready, eg);
        check("alu_en", alu_en, mphase == 1);
        check("rsp_valid", rsp_valid, mphase == 3);
        @(posedge clk);
        case (mphase)
            0: if (widx >= 0) begin
                exp_q.push_back(model_op(widx, opo[widx], opa[widx], opb[widx]));
                mptr   = (widx + 1) % NREQ;
                mphase = 1;
            end
            1: mphase = 2;
            2: mphase = 3;
            default: if (rdy) mphase = 0;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '1;
        req_valid3 = '1;
        rsp_ready  = 1'b0;
        mphase     = 0;
        mptr       = 0;
        exp_q.delete();
        #1;
        check("rst_alu_en", alu_en, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_req_ready3", req_ready3, 0);
        repeat (2) @(negedge clk);
        check("rst_req_ready_hold", req_ready, 0);
        req_valid  = '0;
        req_valid3 = '0;
        rst        = 1'b0;
    endtask

    task automatic txn3(input logic [2:0] v, input logic [2:0] eg, input int eid);
        @(negedge clk);
        req_valid3 = v;
        #1 check("r3_grant", req_ready3, eg);
        repeat (2) begin
            @(negedge clk);
            #1 check("r3_busy_ready", req_ready3, 0);
        end
        @(negedge clk);
        #1;
        check("r3_busy_ready", req_ready3, 0);
        check("r3_rsp_valid", rsp_valid3, 1);
        check("r3_rsp_id", rsp_id3, eid);
        check("r3_rsp_result", rsp_result3, eid + 11);
    endtask

    initial begin : monitor
        rsp_t e;
        rsp_t o;
        bit   held;
        held = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (alu_en) en_count++;
            if (rst || !rsp_valid) begin
                held = 1'b0;
            end else if (!held) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got id %0d result %0h, expected no response", rsp_id, rsp_result);
                end else begin
                    e = exp_q.pop_front();
                    held = 1'b1;
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_result", rsp_result, e.res);
                    check("rsp_carry", rsp_carry, e.c);
                    check("rsp_zero", rsp_zero, e.z);
                    o.id  = int'(rsp_id);
                    o.res = rsp_result;
                    o.c   = rsp_carry;
                    o.z   = rsp_zero;
                    rsp_log.push_back(o);
                end
            end else begin
                check("rsp_hold", {rsp_id, rsp_result, rsp_carry, rsp_zero},
                      {e.id[IDW-1:0], e.res, e.c, e.z});
            end
        end
    end

    initial begin : stim
        int en_before;
        rst        = 1'b0;
        req_valid  = '0;
        rsp_ready  = 1'b1;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        req_valid3 = '0;
        rsp_ready3 = 1'b1;
        req_a3     = {8'd3, 8'd2, 8'd1};
        req_b3     = {8'd10, 8'd10, 8'd10};
        req_op3    = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0; opb[i] = '0; opo[i] = '0;
        end

        // Reset state
        do_reset();
        @(negedge clk);
        #1;
        check("reset_outputs",
              {req_ready, alu_a, alu_b, alu_op, alu_en, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero}, 0);

        // Single op: 250 + 6 wraps to zero with carry
        opa[0] = 8'd250; opb[0] = 8'd6; opo[0] = OP_ADD;
        en_before = en_count;
        rsp_log.delete();
        step(2'b01, 1'b1);
        repeat (5) step(2'b00, 1'b1);
        check("single_en_pulses", en_count - en_before, 1);
        check("single_rsp_count", rsp_log.size(), 1);
        if (rsp_log.size() >= 1)
            check("single_rsp", {rsp_log[0].id[7:0], rsp_log[0].res, rsp_log[0].c, rsp_log[0].z},
                  {8'd0, 8'd0, 1'b1, 1'b1});

        // Contention: both requesters continuously valid
        do_reset();
        opa[0] = 8'd2;  opb[0] = 8'd3;  opo[0] = OP_ADD;
        opa[1] = 8'd23; opb[1] = 8'd20; opo[1] = OP_ADD;
        rsp_log.delete();
        repeat (16) step(2'b11, 1'b1);
        repeat (4) step(2'b00, 1'b1);
        check("contention_count", rsp_log.size(), 4);
        for (int i = 0; i < 4 && i < rsp_log.size(); i++) begin
            check("contention_id", rsp_log[i].id, i % 2);
            check("contention_result", rsp_log[i].res, (i % 2 == 0) ? 5 : 43);
        end

        // Backpressure: requester 1 stays valid while the response is stalled
        do_reset();
        opa[1] = 8'd100; opb[1] = 8'd1; opo[1] = OP_SUB;
        step(2'b10, 1'b1);
        repeat (12) step(2'b10, 1'b0);
        repeat (6) step(2'b10, 1'b1);
        repeat (4) step(2'b00, 1'b1);

        // Reset during CAPTURE after serving requester 0
        do_reset();
        opa[0] = 8'd7; opb[0] = 8'd9; opo[0] = OP_XOR;
        step(2'b01, 1'b1);
        step(2'b00, 1'b1);
        do_reset();
        repeat (4) step(2'b00, 1'b1);
        step(2'b11, 1'b1);
        repeat (3) step(2'b00, 1'b1);
        step(2'b10, 1'b1);
        repeat (4) step(2'b00, 1'b1);

        // Randomized traffic over all opcodes, valids and backpressure
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                opa[i] = N'($urandom);
                opb[i] = N'($urandom);
                opo[i] = 3'($urandom);
            end
            step(NREQ'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end
        repeat (8) step(2'b00, 1'b1);
        check("scoreboard_drain", exp_q.size(), 0);

        // NREQ=3: serve 1 (ptr -> 2), then 2 and 0 contend; 2 wins, then 0, leaving ptr at 1
        do_reset();
        txn3(3'b010, 3'b010, 1);
        txn3(3'b101, 3'b100, 2);
        txn3(3'b101, 3'b001, 0);
        @(negedge clk);
        req_valid3 = 3'b111;
        #1 check("r3_ptr_after_wrap", req_ready3, 3'b010);
        @(negedge clk);
        req_valid3 = '0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
